// File: rtl/conv_window_mac_pkg.sv
// rtl/conv_window_mac_pkg.sv - shared constants and width helper for conv_window_mac
package conv_window_mac_pkg;

    localparam int K_DEF  = 3;
    localparam int IW_DEF = 8;
    localparam int WW_DEF = 4;
    localparam int CH_DEF = 1;
    localparam int OW_DEF = 16;

    // Registered stages from an accepted column to o_valid
    localparam int PIPE_DEPTH = 3;

    // Lossless accumulator width: one product plus growth for K*K*CH terms
    function automatic int accw_f(input int iw, input int ww, input int k, input int ch);
        return iw + ww + 1 + $clog2(k * k * ch);
    endfunction

endpackage

// File: rtl/conv_window_mac_requant.sv
// rtl/conv_window_mac_requant.sv - round, shift, saturate (optional ReLU via CONV_WINDOW_MAC_RELU_EN) output stage
module conv_window_mac_requant
    import conv_window_mac_pkg::*;
#(
    parameter int ACCW = 17,
    parameter int OW   = OW_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   adv_i,
    input  logic                   valid_i,
    input  logic signed [ACCW-1:0] acc_i,
    input  logic [4:0]             shift_i,
    output logic                   valid_o,
    output logic [OW-1:0]          conv_o,
    output logic                   sat_o
);

    // Headroom so the rounding constant for any 5-bit shift never wraps
    localparam int EW = ACCW + 34;
    localparam logic signed [EW-1:0] MAXV = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = ~MAXV;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] shr;
    logic [OW-1:0]        res_d;
    logic                 sat_d;
    logic                 valid_q;
    logic [OW-1:0]        conv_q;
    logic                 sat_q;

    // Round half up, arithmetic shift, clip to the output range
    always_comb begin
        ext   = EW'(acc_i);
        rnd   = '0;
        if (shift_i != 5'd0) begin
            rnd = EW'(1) << (shift_i - 5'd1);
        end
        shr   = (ext + rnd) >>> shift_i;
        sat_d = 1'b0;
        res_d = shr[OW-1:0];
        if (shr > MAXV) begin
            res_d = MAXV[OW-1:0];
            sat_d = 1'b1;
        end else if (shr < MINV) begin
            res_d = MINV[OW-1:0];
            sat_d = 1'b1;
        end
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (res_d[OW-1]) begin
            res_d = '0;
            sat_d = 1'b0;
        end
`endif
    end

    // Output register: one-cycle valid, data held between windows and while frozen
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            conv_q  <= '0;
            sat_q   <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                conv_q <= res_d;
                sat_q  <= sat_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign conv_o  = conv_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - sliding KxK multi-channel window MAC with requantised output; CONV_WINDOW_MAC_RELU_EN enables ReLU
module conv_window_mac
    import conv_window_mac_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int IW = IW_DEF,
    parameter int WW = WW_DEF,
    parameter int CH = CH_DEF,
    parameter int OW = OW_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_valid,
    input  logic                 i_sol,
    input  logic                 i_inhibit,
    input  logic [CH*K*IW-1:0]   i_col_im,
    input  logic [CH*K*WW-1:0]   i_col_ker,
    input  logic [IW-1:0]        i_zero,
    input  logic [4:0]           i_shift,
    output logic                 o_valid,
    output logic [OW-1:0]        o_conv,
    output logic                 o_sat
);

    localparam int ACCW = accw_f(IW, WW, K, CH);
    localparam int PW   = IW + WW + 1;
    localparam int NT   = CH * K * K;
    localparam int FW   = $clog2(K + 1);

    logic adv;
    logic accept;
    assign adv    = !i_inhibit;
    assign accept = i_valid && adv;

    // Window storage indexed (ch*K + row)*K + age, age 0 = newest column
    logic [IW-1:0]          win_im_q  [NT];
    logic [WW-1:0]          win_ker_q [NT];
    logic [FW-1:0]          fill_q, fill_d;
    logic                   v1_q, v2_q, v3_q;
    logic [IW-1:0]          zero1_q;
    logic [4:0]             sh1_q, sh2_q, sh3_q;
    logic signed [PW-1:0]   prod_d [NT];
    logic signed [PW-1:0]   prod_q [NT];
    logic signed [ACCW-1:0] acc_d, acc_q;

    // Fill count: start of line restarts at one, otherwise saturate at K
    always_comb begin
        fill_d = fill_q;
        if (accept) begin
            if (i_sol) begin
                fill_d = FW'(1);
            end else if (fill_q != FW'(K)) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // Shift accepted column into the window and launch when the window is full
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NT; i++) begin
                win_im_q[i]  <= '0;
                win_ker_q[i] <= '0;
            end
            fill_q  <= '0;
            v1_q    <= 1'b0;
            zero1_q <= '0;
            sh1_q   <= '0;
        end else if (adv) begin
            fill_q <= fill_d;
            v1_q   <= accept && (fill_d == FW'(K));
            if (accept) begin
                zero1_q <= i_zero;
                sh1_q   <= i_shift;
                for (int c = 0; c < CH; c++) begin
                    for (int r = 0; r < K; r++) begin
                        for (int j = 0; j < K; j++) begin
                            if (j == 0) begin
                                win_im_q[(c*K+r)*K]  <= i_col_im[(c*K+r)*IW +: IW];
                                win_ker_q[(c*K+r)*K] <= i_col_ker[(c*K+r)*WW +: WW];
                            end else begin
                                win_im_q[(c*K+r)*K+j]  <= win_im_q[(c*K+r)*K+j-1];
                                win_ker_q[(c*K+r)*K+j] <= win_ker_q[(c*K+r)*K+j-1];
                            end
                        end
                    end
                end
            end
        end
    end

    // Zero-point-corrected signed products for every window term
    always_comb begin
        logic signed [IW:0] diff;
        diff = '0;
        for (int i = 0; i < NT; i++) begin
            diff      = $signed({1'b0, win_im_q[i]}) - $signed({1'b0, zero1_q});
            prod_d[i] = PW'(diff) * PW'($signed(win_ker_q[i]));
        end
    end

    // Adder tree over the registered products
    always_comb begin
        acc_d = '0;
        for (int i = 0; i < NT; i++) begin
            acc_d = acc_d + ACCW'(prod_q[i]);
        end
    end

    // Product and sum pipeline registers, frozen with the rest of the block
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NT; i++) begin
                prod_q[i] <= '0;
            end
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            sh2_q <= '0;
            sh3_q <= '0;
            acc_q <= '0;
        end else if (adv) begin
            prod_q <= prod_d;
            v2_q   <= v1_q;
            sh2_q  <= sh1_q;
            v3_q   <= v2_q;
            sh3_q  <= sh2_q;
            acc_q  <= acc_d;
        end
    end

    conv_window_mac_requant #(
        .ACCW (ACCW),
        .OW   (OW)
    ) u_requant (
        .clk     (clk),
        .rstn    (rstn),
        .adv_i   (adv),
        .valid_i (v3_q),
        .acc_i   (acc_q),
        .shift_i (sh3_q),
        .valid_o (o_valid),
        .conv_o  (o_conv),
        .sat_o   (o_sat)
    );

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - self-checking bench for conv_window_mac (CONV_WINDOW_MAC_RELU_EN aware)
module tb_conv_window_mac;
    import conv_window_mac_pkg::*;

    localparam int K  = 3;
    localparam int IW = 8;
    localparam int WW = 4;
    localparam int CH = 4;
    localparam int OW = 16;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 i_valid, i_sol, i_inhibit;
    logic [CH*K*IW-1:0]   i_col_im;
    logic [CH*K*WW-1:0]   i_col_ker;
    logic [IW-1:0]        i_zero;
    logic [4:0]           i_shift;
    logic                 o_valid;
    logic [OW-1:0]        o_conv;
    logic                 o_sat;

    conv_window_mac #(.K(K), .IW(IW), .WW(WW), .CH(CH), .OW(OW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_valid   (i_valid),
        .i_sol     (i_sol),
        .i_inhibit (i_inhibit),
        .i_col_im  (i_col_im),
        .i_col_ker (i_col_ker),
        .i_zero    (i_zero),
        .i_shift   (i_shift),
        .o_valid   (o_valid),
        .o_conv    (o_conv),
        .o_sat     (o_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH*K*IW-1:0] im;
        logic [CH*K*WW-1:0] ker;
    } col_t;

    typedef struct {
        longint        due;
        logic [OW-1:0] conv;
        logic          sat;
    } exp_t;

    col_t          line_q[$];
    exp_t          exp_q[$];
    longint        adv_n = 0;
    logic          m_valid = 1'b0;
    logic [OW-1:0] m_conv = '0;
    logic          m_sat = 1'b0;
    logic          adv_e;
    int            win_count = 0;
    logic [OW-1:0] last_conv = '0;
    logic          last_sat = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: sum over the last K columns of the current line, then requantise
    function automatic exp_t ref_window(input longint due, input logic [IW-1:0] z, input logic [4:0] sh);
        longint sum, v, maxv, minv;
        exp_t   e;
        col_t   cl;
        sum = 0;
        for (int j = 0; j < K; j++) begin
            cl = line_q[j];
            for (int c = 0; c < CH; c++) begin
                for (int r = 0; r < K; r++) begin
                    logic [IW-1:0]        p;
                    logic signed [WW-1:0] w;
                    p = cl.im[(c*K+r)*IW +: IW];
                    w = cl.ker[(c*K+r)*WW +: WW];
                    sum += (longint'(p) - longint'(z)) * longint'(w);
                end
            end
        end
        v = sum;
        if (sh != 5'd0) v += longint'(1) << (sh - 1);
        v = v >>> sh;
        maxv  = (longint'(1) << (OW - 1)) - 1;
        minv  = -(longint'(1) << (OW - 1));
        e.sat = 1'b0;
        if (v > maxv) begin
            v = maxv; e.sat = 1'b1;
        end else if (v < minv) begin
            v = minv; e.sat = 1'b1;
        end
`ifdef CONV_WINDOW_MAC_RELU_EN
        if (v < 0) begin
            v = 0; e.sat = 1'b0;
        end
`endif
        e.conv = OW'(v);
        e.due  = due;
        return e;
    endfunction

    // Cycle model of the observable outputs, compared just after every edge
    always @(posedge clk) begin
        col_t cl;
        adv_e = 1'b0;
        if (!rstn) begin
            line_q.delete();
            exp_q.delete();
            m_valid = 1'b0;
            m_conv  = '0;
            m_sat   = 1'b0;
        end else if (!i_inhibit) begin
            adv_e = 1'b1;
            adv_n++;
            if (exp_q.size() > 0 && exp_q[0].due == adv_n) begin
                m_valid = 1'b1;
                m_conv  = exp_q[0].conv;
                m_sat   = exp_q[0].sat;
                void'(exp_q.pop_front());
            end else begin
                m_valid = 1'b0;
            end
            if (i_valid) begin
                if (i_sol) line_q.delete();
                cl.im  = i_col_im;
                cl.ker = i_col_ker;
                line_q.push_back(cl);
                if (line_q.size() > K) void'(line_q.pop_front());
                if (line_q.size() == K) exp_q.push_back(ref_window(adv_n + PIPE_DEPTH, i_zero, i_shift));
            end
        end
        #1;
        if (rstn) begin
            check("o_valid", o_valid, m_valid);
            check("o_conv", o_conv, m_conv);
            check("o_sat", o_sat, m_sat);
            if (adv_e && o_valid) begin
                win_count++;
                last_conv = o_conv;
                last_sat  = o_sat;
            end
        end
    end

    function automatic logic [CH*K*IW-1:0] fill_im(input logic [IW-1:0] p);
        logic [CH*K*IW-1:0] v;
        for (int i = 0; i < CH*K; i++) v[i*IW +: IW] = p;
        return v;
    endfunction

    function automatic logic [CH*K*WW-1:0] fill_ker(input logic [WW-1:0] w, input int nch);
        logic [CH*K*WW-1:0] v;
        v = '0;
        for (int i = 0; i < nch*K; i++) v[i*WW +: WW] = w;
        return v;
    endfunction

    task automatic send_col(input logic sol, input logic [CH*K*IW-1:0] im, input logic [CH*K*WW-1:0] ker,
                            input logic [IW-1:0] z, input logic [4:0] sh);
        @(negedge clk);
        i_valid = 1'b1; i_sol = sol; i_col_im = im; i_col_ker = ker; i_zero = z; i_shift = sh;
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_sol = 1'b0;
    endtask

    // One window whose only non-zero term is pixel p times weight w
    task automatic single_term(input string tag, input logic [IW-1:0] p, input logic [WW-1:0] w,
                               input logic [4:0] sh, input logic [OW-1:0] exp_conv, input logic exp_sat);
        logic [CH*K*WW-1:0] k1;
        int base;
        k1 = '0;
        k1[WW-1:0] = w;
        base = win_count;
        send_col(1'b1, fill_im(p), k1, '0, sh);
        send_col(1'b0, fill_im(p), '0, '0, sh);
        send_col(1'b0, fill_im(p), '0, '0, sh);
        repeat (5) @(negedge clk);
        check({tag, "_count"}, win_count - base, 1);
        check({tag, "_conv"}, last_conv, exp_conv);
        check({tag, "_sat"}, last_sat, exp_sat);
    endtask

    initial begin
        int base;
        rstn = 1'b0; i_valid = 1'b0; i_sol = 1'b0; i_inhibit = 1'b0;
        i_col_im = '0; i_col_ker = '0; i_zero = '0; i_shift = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_conv", o_conv, 0);
        check("rst_sat", o_sat, 0);
        rstn = 1'b1;

        // Ones window on channel 0: value 9 exactly three edges after the third column
        send_col(1'b1, fill_im(8'd1), fill_ker(4'd1, 1), '0, '0);
        send_col(1'b0, fill_im(8'd1), fill_ker(4'd1, 1), '0, '0);
        send_col(1'b0, fill_im(8'd1), fill_ker(4'd1, 1), '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ones_early", o_valid, 0);
        end
        @(negedge clk);
        check("ones_valid", o_valid, 1);
        check("ones_conv", o_conv, 9);
        repeat (3) @(negedge clk);

        single_term("rnd_p17", 8'd17, 4'd1, 5'd1, 16'd9, 1'b0);
`ifdef CONV_WINDOW_MAC_RELU_EN
        single_term("rnd_m17", 8'd17, 4'hF, 5'd1, 16'd0, 1'b0);
        single_term("neg40", 8'd5, 4'h8, 5'd0, 16'd0, 1'b0);
`else
        single_term("rnd_m17", 8'd17, 4'hF, 5'd1, 16'hFFF8, 1'b0);
        single_term("neg40", 8'd5, 4'h8, 5'd0, 16'hFFD8, 1'b0);
`endif
        single_term("rnd_5", 8'd5, 4'd1, 5'd0, 16'd5, 1'b0);

        // Saturation with every channel at full scale
        base = win_count;
        for (int i = 0; i < K; i++) send_col(i == 0, fill_im(8'd255), fill_ker(4'd7, CH), '0, '0);
        repeat (5) @(negedge clk);
        check("satp_count", win_count - base, 1);
        check("satp_conv", last_conv, 16'h7FFF);
        check("satp_sat", last_sat, 1);
        for (int i = 0; i < K; i++) send_col(i == 0, fill_im(8'd255), fill_ker(4'h8, CH), '0, '0);
        repeat (5) @(negedge clk);
`ifdef CONV_WINDOW_MAC_RELU_EN
        check("satn_conv", last_conv, 16'h0000);
        check("satn_sat", last_sat, 0);
`else
        check("satn_conv", last_conv, 16'h8000);
        check("satn_sat", last_sat, 1);
`endif

        // Line restart on column 6: windows for columns 3,4,5 and 8 only
        base = win_count;
        for (int i = 1; i <= 8; i++)
            send_col(i == 1 || i == 6, fill_im(i >= 6 ? 8'd2 : 8'd100), fill_ker(4'd1, 1), '0, '0);
        repeat (6) @(negedge clk);
        check("sol_count", win_count - base, 4);
        check("sol_conv", last_conv, 18);

        // Two inhibited cycles inside a full-rate stream
        base = win_count;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            i_valid = 1'b1; i_sol = (i == 0); i_inhibit = (i == 4 || i == 5);
            i_col_im = {$urandom(), $urandom(), $urandom()};
            i_col_ker = CH*K*WW'({$urandom(), $urandom()});
            i_zero = IW'($urandom()); i_shift = 5'($urandom_range(0, 6));
        end
        @(negedge clk);
        i_valid = 1'b0; i_sol = 1'b0; i_inhibit = 1'b0;
        repeat (6) @(negedge clk);
        check("inh_count", win_count - base, 4);

        // Randomised traffic with a reset in the middle
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (i == 400) begin
                rstn = 1'b0;
                #1;
                check("mid_rst_valid", o_valid, 0);
                check("mid_rst_conv", o_conv, 0);
                check("mid_rst_sat", o_sat, 0);
            end
            if (i == 403) rstn = 1'b1;
            i_valid   = ($urandom_range(0, 9) < 8);
            i_sol     = ($urandom_range(0, 15) == 0);
            i_inhibit = ($urandom_range(0, 6) == 0);
            i_col_im  = {$urandom(), $urandom(), $urandom()};
            i_col_ker = CH*K*WW'({$urandom(), $urandom()});
            i_zero    = IW'($urandom());
            i_shift   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
        end
        @(negedge clk);
        i_valid = 1'b0; i_sol = 1'b0; i_inhibit = 1'b0;
        repeat (8) @(negedge clk);
        check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_window_mac.md
CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 SHALL have parameter K, default 3; kernel height/width.
REQ-002 SHALL have parameter IW, default 8; unsigned pixel width.
REQ-003 SHALL have parameter WW, default 4; signed two's-complement weight width.
REQ-004 SHALL have parameter CH, default 1; channels summed in parallel.
REQ-005 SHALL have parameter OW, default 16; signed output width.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port i_valid, input, 1: i_col_im/i_col_ker hold a new column.
REQ-009 SHALL have port i_sol, input, 1: start of line; qualified by i_valid.
REQ-010 SHALL have port i_inhibit, input, 1: freezes the whole block.
REQ-011 SHALL have port i_col_im, input, CH*K*IW: one K-pixel column per channel, row 0 in the LSBs, channel 0 lowest.
REQ-012 SHALL have port i_col_ker, input, CH*K*WW: matching weight column, same packing.
REQ-013 SHALL have port i_zero, input, IW: pixel zero point.
REQ-014 SHALL have port i_shift, input, 5: requantisation right-shift.
REQ-015 SHALL have port o_valid, output, 1: o_conv/o_sat valid.
REQ-016 SHALL have port o_conv, output, OW: requantised window result.
REQ-017 SHALL have port o_sat, output, 1: o_conv was clipped.

Function
REQ-018 SHALL accept a column only when i_valid=1 and i_inhibit=0; an accepted column shifts into a per-channel KxK window, and the oldest column drops out.
REQ-019 SHALL keep a fill counter saturating at K; an accepted column with i_sol=1 loads the counter to 1; i_sol with i_valid=0 is ignored.
REQ-020 SHALL launch one window computation per accepted column that leaves the fill counter at K.
REQ-021 SHALL compute each term as signed(pixel - i_zero), IW+1 bits, times the signed weight, giving IW+WW+1 bits.
REQ-022 SHALL sum all K*K*CH terms losslessly in an ACCW = IW+WW+1+clog2(K*K*CH) bit accumulator.
REQ-023 SHALL requantise as follows: if i_shift>0, add 2^(i_shift-1); then arithmetic-shift right by i_shift; then saturate to [-2^(OW-1), 2^(OW-1)-1]; o_sat=1 when clipped.
REQ-024 SHALL sample i_zero and i_shift with the column and pipeline them, so that a change applies per window.
REQ-025 SHALL use a 3-stage pipeline (window/product, adder tree, requant): a column accepted at edge n yields o_valid=1 after edge n+3.
REQ-026 SHALL hold o_valid=1 for exactly one cycle per window while not inhibited; o_conv/o_sat SHALL keep their last value when o_valid=0.
REQ-027 SHALL, while i_inhibit=1, hold every register including o_valid, o_conv and o_sat; it SHALL never drop or duplicate a window.
REQ-028 SHALL accept back-to-back columns at full rate, one per cycle.

Reset
REQ-029 SHALL on rstn=0 clear windows, fill counter, pipeline valids, o_valid, o_conv and o_sat to 0 asynchronously.
REQ-030 SHALL after reset release require K fresh accepted columns before the first window; in-flight windows SHALL be discarded.

Configuration
REQ-031 SHALL, with CONV_WINDOW_MAC_RELU_EN defined, force negative post-saturation results to 0 without setting o_sat; without the macro, output is the full signed range.

Structure
REQ-032 SHALL place in package conv_window_mac_pkg: the default parameter constants, the ACCW width function, and the pipeline-depth constant (3).
REQ-033 SHALL implement round/shift/saturate/ReLU in sub-module conv_window_mac_requant, a single registered stage.

Verification
REQ-034 SHALL cover: K=3, CH=1, all pixels 1, weights 1, i_zero=0, i_shift=0, 3 columns -> one o_conv=9 exactly 3 cycles after the third column.
REQ-035 SHALL cover rounding: sum 17 with i_shift=1 -> 9; sum -17 with i_shift=1 -> -8; sum 5 with i_shift=0 -> 5.
REQ-036 SHALL cover saturation: CH=4, pixels 255, weights 7 -> 0x7FFF with o_sat=1; weights -8 -> 0x8000 with o_sat=1 (without the macro).
REQ-037 SHALL cover line restart: i_sol on column 6 -> no o_valid for columns 6-7, a window for column 8 computed only from columns 6-8.
REQ-038 SHALL cover inhibit: i_inhibit for 2 cycles mid-stream with i_valid=1 -> outputs frozen, and the output sequence equals the golden sequence with no loss or duplication.
REQ-039 SHALL cover the macro: a window with sum -40 -> o_conv=0 with CONV_WINDOW_MAC_RELU_EN, 0xFFD8 without it.
